// File: rtl/risk_pkg.sv
// Shared constants and types for the RISK 4x4 tile load/store paths.
// Element address: bank = addr[6:0], row = addr[16:7].
package risk_pkg;

    localparam int RISK_ADDR_W   = 17;
    localparam int RISK_ELEM_W   = 18;
    localparam int RISK_ROW_W    = 10;
    localparam int RISK_BANK_W   = 7;
    localparam int RISK_NELEM    = 16;
    localparam int RISK_STRIDE_W = 15;
    localparam int RISK_NBANKS   = 128;
    localparam int RISK_TILE_N   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } risk_state_e;

    typedef logic [RISK_ADDR_W-1:0] risk_addr_t;

    // stride * k for k in 0..3 using shift-add, truncated to the address width
    function automatic risk_addr_t risk_stride_mul(input logic [RISK_STRIDE_W-1:0] stride,
                                                   input logic [1:0] k);
        risk_addr_t s;
        s = risk_addr_t'(stride);
        return (k[0] ? s : '0) + (k[1] ? risk_addr_t'(s << 1) : '0);
    endfunction

endpackage

// File: rtl/risk_scatter_store_if.sv
// Request handshake and bank write bus of the RISK tile scatter store.
interface risk_scatter_store_if;
    import risk_pkg::*;

    logic                                 req_valid;
    logic                                 req_ready;
    logic [RISK_ADDR_W-1:0]               req_addr;
    logic [RISK_STRIDE_W-1:0]             req_stride_x;
    logic [RISK_STRIDE_W-1:0]             req_stride_y;
    logic [RISK_NELEM*RISK_ELEM_W-1:0]    req_data;
    logic [RISK_NBANKS-1:0]               bank_we;
    logic [RISK_NBANKS*RISK_ROW_W-1:0]    bank_addr;
    logic [RISK_NBANKS*RISK_ELEM_W-1:0]   bank_data;
    logic                                 busy;
    logic                                 done;

    modport master (
        output req_valid, req_addr, req_stride_x, req_stride_y, req_data,
        input  req_ready, bank_we, bank_addr, bank_data, busy, done
    );

    modport slave (
        input  req_valid, req_addr, req_stride_x, req_stride_y, req_data,
        output req_ready, bank_we, bank_addr, bank_data, busy, done
    );

endinterface

// File: rtl/risk_bank_arb.sv
// Per-bank lowest-index pick over the 16 pending element addresses.
// Combinational; sel is one-hot per bank, grant is the union of all picks.
module risk_bank_arb
    import risk_pkg::*;
(
    input  logic [RISK_NELEM-1:0]                   pending,
    input  logic [RISK_NELEM-1:0][RISK_ADDR_W-1:0]  addr,
    output logic [RISK_NELEM-1:0]                   grant,
    output logic [RISK_NBANKS-1:0]                  hit,
    output logic [RISK_NBANKS-1:0][RISK_NELEM-1:0]  sel
);

    always_comb begin
        sel   = '0;
        hit   = '0;
        grant = '0;
        for (int i = 0; i < RISK_NBANKS; i++) begin
            for (int j = 0; j < RISK_NELEM; j++) begin
                if (pending[j] && !hit[i] &&
                    (addr[j][RISK_BANK_W-1:0] == RISK_BANK_W'(i))) begin
                    sel[i][j] = 1'b1;
                    hit[i]    = 1'b1;
                    grant[j]  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/risk_scatter_store.sv
// RISK tile store: scatters a 4x4 tile into the 128-bank memory at base + sx*x + sy*y,
// serialising same-bank elements in raster order so the highest index lands last.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request, tile/base/strides latched on accept
// ST_CALC  | element addresses registered, pending mask set to all ones
// ST_WRITE | each bank writes its lowest pending element per cycle
// ST_DONE  | one-cycle done pulse, no writes
module risk_scatter_store
    import risk_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    risk_scatter_store_if.slave  bus
);

    risk_state_e                                state_q, state_d;
    logic [RISK_NELEM-1:0][RISK_ELEM_W-1:0]     data_q;
    risk_addr_t                                 base_q;
    logic [RISK_STRIDE_W-1:0]                   sx_q, sy_q;
    logic [RISK_NELEM-1:0][RISK_ADDR_W-1:0]     addr_q, addr_calc;
    logic [RISK_NELEM-1:0]                      pending_q, pending_d, grant;
    logic [RISK_NBANKS-1:0]                     hit;
    logic [RISK_NBANKS-1:0][RISK_NELEM-1:0]     sel;
    logic [RISK_NBANKS-1:0][RISK_ROW_W-1:0]     row_q, row_d;
    logic [RISK_NBANKS-1:0][RISK_ELEM_W-1:0]    wdat_q, wdat_d;
    logic                                       accept;
    logic                                       write_en;

    assign accept   = (state_q == ST_IDLE) && bus.req_valid;
    assign write_en = (state_q == ST_WRITE);

    always_comb begin
        addr_calc = '0;
        for (int j = 0; j < RISK_NELEM; j++) begin
            addr_calc[j] = base_q
                         + risk_stride_mul(sx_q, 2'(j))
                         + risk_stride_mul(sy_q, 2'(j >> 2));
        end
    end

    risk_bank_arb u_arb (
        .pending (pending_q),
        .addr    (addr_q),
        .grant   (grant),
        .hit     (hit),
        .sel     (sel)
    );

    assign pending_d = pending_q & ~grant;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_CALC;
            ST_CALC:  state_d = ST_WRITE;
            ST_WRITE: if (pending_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            data_q    <= '0;
            base_q    <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            addr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= bus.req_data;
                base_q <= bus.req_addr;
                sx_q   <= bus.req_stride_x;
                sy_q   <= bus.req_stride_y;
            end
            if (state_q == ST_CALC) begin
                addr_q    <= addr_calc;
                pending_q <= '1;
            end else if (write_en) begin
                pending_q <= pending_d;
            end
        end
    end

    // Banks not written this cycle keep their last row/data on the bus
    always_comb begin
        row_d  = row_q;
        wdat_d = wdat_q;
        for (int i = 0; i < RISK_NBANKS; i++) begin
            for (int j = 0; j < RISK_NELEM; j++) begin
                if (write_en && sel[i][j]) begin
                    row_d[i]  = addr_q[j][RISK_ADDR_W-1:RISK_BANK_W];
                    wdat_d[i] = data_q[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_q  <= '0;
            wdat_q <= '0;
        end else begin
            row_q  <= row_d;
            wdat_q <= wdat_d;
        end
    end

    assign bus.bank_we   = write_en ? hit : '0;
    assign bus.bank_addr = row_d;
    assign bus.bank_data = wdat_d;
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_risk_scatter_store.sv
// Directed bench for risk_scatter_store: timing and bank contents checked against
// hand-computed values, sampling 1ns after each rising edge.
module tb_risk_scatter_store;
    import risk_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    risk_scatter_store_if bus ();

    risk_scatter_store dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    function automatic logic [9:0] row_of(input int i);
        return bus.bank_addr[i*10 +: 10];
    endfunction

    function automatic logic [17:0] dat_of(input int i);
        return bus.bank_data[i*18 +: 18];
    endfunction

    task automatic load_req(input logic [16:0] a, input logic [14:0] sx,
                            input logic [14:0] sy, input logic [17:0] e0);
        bus.req_addr     = a;
        bus.req_stride_x = sx;
        bus.req_stride_y = sy;
        for (int j = 0; j < 16; j++) bus.req_data[j*18 +: 18] = e0 + 18'(j);
    endtask

    // Returns 1ns after the accept edge T; ok=0 if never ready within the budget.
    task automatic issue(input bit keep, output bit ok);
        int cyc;
        cyc = 0;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        ok = bus.req_ready;
        @(posedge clk); #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_tests++; if (bus.bank_we !== '0) begin n_fail++; $display("FAIL reset_bank_we got %h want 0", bus.bank_we); end
        n_tests++; if (bus.bank_addr !== '0) begin n_fail++; $display("FAIL reset_bank_addr nonzero"); end
        n_tests++; if (bus.bank_data !== '0) begin n_fail++; $display("FAIL reset_bank_data nonzero"); end
        @(posedge clk); #1;
        resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_contiguous();
        bit ok;
        logic [127:0] exp_we;
        load_req(17'd0, 15'd1, 15'd4, 18'd1);
        issue(1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL contig_accept timed out"); end
        next_cycle();
        exp_we = 128'h0;
        exp_we[15:0] = 16'hFFFF;
        n_tests++; if (bus.bank_we !== exp_we) begin n_fail++; $display("FAIL contig_we got %h want %h", bus.bank_we, exp_we); end
        for (int j = 0; j < 16; j++) begin
            n_tests++; if (row_of(j) !== 10'd0 || dat_of(j) !== 18'(j+1)) begin n_fail++; $display("FAIL contig_bank%0d row %0d data %h want row 0 data %h", j, row_of(j), dat_of(j), j+1); end
        end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL contig_early_done got %b want 0", bus.done); end
        next_cycle();
        n_tests++; if (bus.done !== 1'b1 || bus.bank_we !== '0) begin n_fail++; $display("FAIL contig_done done %b we %h want 1/0", bus.done, bus.bank_we); end
        n_tests++; if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL contig_busy ready %b busy %b want 0/1", bus.req_ready, bus.busy); end
        next_cycle();
        n_tests++; if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL contig_idle done %b ready %b want 0/1", bus.done, bus.req_ready); end
    endtask

    task automatic test_full_conflict();
        bit ok;
        load_req(17'd0, 15'd128, 15'd512, 18'h200);
        issue(1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL conflict_accept timed out"); end
        for (int k = 0; k < 16; k++) begin
            next_cycle();
            n_tests++; if (bus.bank_we !== 128'd1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL conflict_we%0d got %h done %b want 1/0", k, bus.bank_we, bus.done); end
            n_tests++; if (row_of(0) !== 10'(k) || dat_of(0) !== 18'(18'h200 + k)) begin n_fail++; $display("FAIL conflict_w%0d row %0d data %h want row %0d data %h", k, row_of(0), dat_of(0), k, 18'h200 + k); end
        end
        next_cycle();
        n_tests++; if (bus.done !== 1'b1 || bus.bank_we !== '0) begin n_fail++; $display("FAIL conflict_done done %b we %h want 1/0", bus.done, bus.bank_we); end
        next_cycle();
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL conflict_idle ready %b want 1", bus.req_ready); end
    endtask

    task automatic test_duplicates();
        bit ok;
        load_req(17'd5, 15'd0, 15'd0, 18'h100);
        issue(1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL dup_accept timed out"); end
        for (int k = 0; k < 16; k++) begin
            next_cycle();
            n_tests++; if (bus.bank_we !== (128'd1 << 5) || row_of(5) !== 10'd0 || dat_of(5) !== 18'(18'h100 + k)) begin n_fail++; $display("FAIL dup_w%0d we %h row %0d data %h want bank5 row 0 data %h", k, bus.bank_we, row_of(5), dat_of(5), 18'h100 + k); end
        end
        next_cycle();
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL dup_done got %b want 1", bus.done); end
        n_tests++; if (dat_of(5) !== 18'h10F) begin n_fail++; $display("FAIL dup_last got %h want 10f", dat_of(5)); end
        next_cycle();
    endtask

    task automatic test_wraparound();
        bit ok;
        logic [127:0] exp_we;
        load_req(17'h1FFFF, 15'd1, 15'd0, 18'h3000);
        issue(1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_accept timed out"); end
        next_cycle();
        exp_we = 128'h0;
        exp_we[127] = 1'b1; exp_we[0] = 1'b1; exp_we[1] = 1'b1; exp_we[2] = 1'b1;
        n_tests++; if (bus.bank_we !== exp_we) begin n_fail++; $display("FAIL wrap_we got %h want %h", bus.bank_we, exp_we); end
        n_tests++; if (row_of(127) !== 10'd1023 || dat_of(127) !== 18'h3000) begin n_fail++; $display("FAIL wrap_elem0 row %0d data %h want 1023/3000", row_of(127), dat_of(127)); end
        n_tests++; if (row_of(0) !== 10'd0 || dat_of(0) !== 18'h3001) begin n_fail++; $display("FAIL wrap_elem1 row %0d data %h want 0/3001", row_of(0), dat_of(0)); end
        next_cycle();
        n_tests++; if (dat_of(127) !== 18'h3004 || dat_of(2) !== 18'h3007) begin n_fail++; $display("FAIL wrap_second b127 %h b2 %h want 3004/3007", dat_of(127), dat_of(2)); end
        next_cycle();
        next_cycle();
        n_tests++; if (bus.done !== 1'b0 || dat_of(127) !== 18'h300C) begin n_fail++; $display("FAIL wrap_fourth done %b b127 %h want 0/300c", bus.done, dat_of(127)); end
        next_cycle();
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %b want 1", bus.done); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [127:0] exp_we;
        load_req(17'd0, 15'd1, 15'd4, 18'd1);
        issue(1'b1, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_accept timed out"); end
        load_req(17'd16, 15'd1, 15'd4, 18'h40);
        n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_calc got %b want 0", bus.req_ready); end
        next_cycle();
        n_tests++; if (bus.req_ready !== 1'b0 || dat_of(0) !== 18'd1) begin n_fail++; $display("FAIL b2b_first_write ready %b b0 %h want 0/1", bus.req_ready, dat_of(0)); end
        next_cycle();
        n_tests++; if (bus.req_ready !== 1'b0 || bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done ready %b done %b want 0/1", bus.req_ready, bus.done); end
        next_cycle();
        n_tests++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle ready %b busy %b want 1/0", bus.req_ready, bus.busy); end
        next_cycle();
        bus.req_valid = 1'b0;
        n_tests++; if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept ready %b busy %b want 0/1", bus.req_ready, bus.busy); end
        next_cycle();
        exp_we = 128'h0;
        exp_we[31:16] = 16'hFFFF;
        n_tests++; if (bus.bank_we !== exp_we || dat_of(16) !== 18'h40 || dat_of(31) !== 18'h4F) begin n_fail++; $display("FAIL b2b_second_write we %h b16 %h b31 %h want %h/40/4f", bus.bank_we, dat_of(16), dat_of(31), exp_we); end
        next_cycle();
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got %b want 1", bus.done); end
        next_cycle();
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int seen_done;
        load_req(17'd0, 15'd128, 15'd512, 18'h200);
        issue(1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL midrst_accept timed out"); end
        for (int k = 0; k < 5; k++) next_cycle();
        n_tests++; if (bus.bank_we !== 128'd1 || row_of(0) !== 10'd4) begin n_fail++; $display("FAIL midrst_write5 we %h row %0d want 1/4", bus.bank_we, row_of(0)); end
        resetn = 1'b0;
        #1;
        n_tests++; if (bus.bank_we !== '0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_abort we %h done %b want 0/0", bus.bank_we, bus.done); end
        n_tests++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.bank_addr !== '0) begin n_fail++; $display("FAIL midrst_outputs ready %b busy %b want 1/0 addr zeroed", bus.req_ready, bus.busy); end
        @(posedge clk); #1;
        resetn = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            if (bus.done !== 1'b0 || bus.bank_we !== '0) seen_done++;
        end
        n_tests++; if (seen_done != 0) begin n_fail++; $display("FAIL midrst_quiet got %0d active cycles want 0", seen_done); end
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", bus.req_ready); end
        test_contiguous();
    endtask

    initial begin
        resetn           = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_stride_x = '0;
        bus.req_stride_y = '0;
        bus.req_data     = '0;
        test_reset();
        test_contiguous();
        test_full_conflict();
        test_duplicates();
        test_wraparound();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
